// File: rtl/readout_rx_integrator_pkg.sv
// Shared readout RX integrator definitions: FSM encodings and default widths.
package readout_rx_integrator_pkg;

  localparam int RX_IQ_IN_WIDTH = 16;
  localparam int RX_ACC_WIDTH   = 24;
  localparam int RX_LEN_WIDTH   = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } rx_int_state_e;

endpackage

// File: rtl/readout_rx_sat_accumulator.sv
// Signed saturating accumulator: sign-extends each sample, adds, clamps to the
// ACC_WIDTH signed range so an overflowing window pins at full scale.
module readout_rx_sat_accumulator #(
  parameter int IQ_IN_WIDTH = 16,
  parameter int ACC_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [IQ_IN_WIDTH-1:0] din,
  output logic [ACC_WIDTH-1:0]   acc
);

  logic [ACC_WIDTH:0]   acc_ext_s;
  logic [ACC_WIDTH:0]   din_ext_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic [ACC_WIDTH-1:0] sat_s;
  logic [ACC_WIDTH-1:0] acc_r;

  // Clamp a one-bit-wider sum back into ACC_WIDTH; the top two bits disagree on overflow.
  function automatic logic [ACC_WIDTH-1:0] sat_fn(input logic [ACC_WIDTH:0] v);
    logic [ACC_WIDTH-1:0] r;
    if (v[ACC_WIDTH] != v[ACC_WIDTH-1]) begin
      if (v[ACC_WIDTH]) begin
        r = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        r = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      r = v[ACC_WIDTH-1:0];
    end
    return r;
  endfunction

  // Sign-extended add and saturation.
  always_comb begin
    acc_ext_s = {acc_r[ACC_WIDTH-1], acc_r};
    din_ext_s = {{(ACC_WIDTH+1-IQ_IN_WIDTH){din[IQ_IN_WIDTH-1]}}, din};
    sum_s     = acc_ext_s + din_ext_s;
    sat_s     = sat_fn(sum_s);
  end

  // Accumulator register: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {ACC_WIDTH{1'b0}};
    end else if (clr) begin
      acc_r <= {ACC_WIDTH{1'b0}};
    end else if (en) begin
      acc_r <= sat_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/readout_rx_integrator.sv
// Integrates calibrated I/Q over a programmable window and reports the totals
// plus a threshold-based qubit state decision on I.
module readout_rx_integrator
  import readout_rx_integrator_pkg::*;
#(
  parameter int IQ_IN_WIDTH = RX_IQ_IN_WIDTH,
  parameter int ACC_WIDTH   = RX_ACC_WIDTH,
  parameter int LEN_WIDTH   = RX_LEN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [LEN_WIDTH-1:0]   window_len,
  input  logic [ACC_WIDTH-1:0]   threshold,
  input  logic [IQ_IN_WIDTH-1:0] i_in,
  input  logic [IQ_IN_WIDTH-1:0] q_in,
  input  logic                   valid_in,
  output logic                   busy,
  output logic [ACC_WIDTH-1:0]   i_acc_out,
  output logic [ACC_WIDTH-1:0]   q_acc_out,
  output logic                   state_out,
  output logic                   valid_out
);

  rx_int_state_e        state_r;
  rx_int_state_e        state_nx_s;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] cnt_inc_s;
  logic                 start_ok_s;
  logic                 acc_clr_s;
  logic                 acc_en_s;
  logic [ACC_WIDTH-1:0] i_acc_s;
  logic [ACC_WIDTH-1:0] q_acc_s;

  assign cnt_inc_s = cnt_r + {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  // Next-state decode; abort wins over a simultaneous sample.
  always_comb begin
    state_nx_s = state_r;
    start_ok_s = 1'b0;
    acc_clr_s  = 1'b0;
    acc_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (window_len != {LEN_WIDTH{1'b0}})) begin
          state_nx_s = ST_ACCUM;
          start_ok_s = 1'b1;
          acc_clr_s  = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
          acc_clr_s  = 1'b1;
        end else if (valid_in) begin
          acc_en_s = 1'b1;
          if (cnt_inc_s == len_r) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_ACCUM;
          end
        end else begin
          state_nx_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, sample counter, latched length and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {LEN_WIDTH{1'b0}};
      len_r   <= {LEN_WIDTH{1'b0}};
      busy    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s != ST_IDLE);
      if (acc_clr_s) begin
        cnt_r <= {LEN_WIDTH{1'b0}};
      end else if (acc_en_s) begin
        cnt_r <= cnt_inc_s;
      end else begin
        cnt_r <= cnt_r;
      end
      if (start_ok_s) begin
        len_r <= window_len;
      end else begin
        len_r <= len_r;
      end
    end
  end

  readout_rx_sat_accumulator #(
    .IQ_IN_WIDTH(IQ_IN_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc_i (
    .clk(clk),
    .rst(rst),
    .clr(acc_clr_s),
    .en (acc_en_s),
    .din(i_in),
    .acc(i_acc_s)
  );

  readout_rx_sat_accumulator #(
    .IQ_IN_WIDTH(IQ_IN_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc_q (
    .clk(clk),
    .rst(rst),
    .clr(acc_clr_s),
    .en (acc_en_s),
    .din(q_in),
    .acc(q_acc_s)
  );

  // Result registers: captured in DONE and held until the next result.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_acc_out <= {ACC_WIDTH{1'b0}};
      q_acc_out <= {ACC_WIDTH{1'b0}};
      state_out <= 1'b0;
      valid_out <= 1'b0;
    end else if (state_r == ST_DONE) begin
      i_acc_out <= i_acc_s;
      q_acc_out <= q_acc_s;
      state_out <= ($signed(i_acc_s) >= $signed(threshold));
      valid_out <= 1'b1;
    end else begin
      i_acc_out <= i_acc_out;
      q_acc_out <= q_acc_out;
      state_out <= state_out;
      valid_out <= 1'b0;
    end
  end

endmodule
